writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage of the RV32I core. Sits directly upstream of the register file. Accepts one retiring instruction's result sources, waits for load data from data memory where needed, and extracts and extends the load byte or halfword. It then drives the register file's `rd_addr`, `rd_data` and `reg_write_enable` for exactly one cycle per instruction.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT_MEM before a load is aborted; legal range 1..255.
- `clk` input 1: sole clock; all state updates on posedge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `wb_valid` input 1: instruction offered; accepted when `wb_valid && !busy`.
- `wb_sel` input 2: result source: 00 ALU, 01 LOAD, 10 PC+4, 11 IMM.
- `funct3` input 3: load width/sign; used only for LOAD.
- `rd_in` input 5: destination register.
- `alu_result` input 32: ALU result; for LOAD, the byte address (bits [1:0] = offset).
- `pc_plus4` input 32: link value.
- `imm` input 32: immediate (LUI).
- `mem_rdata` input 32: aligned word from data memory.
- `mem_rvalid` input 1: `mem_rdata` valid this cycle.
- `rd_addr` output 5: to register file.
- `rd_data` output 32: to register file.
- `reg_write_enable` output 1: to register file.
- `busy` output 1: unit cannot accept.
- `done` output 1: one-cycle retire pulse.
- `fault` output 1: one-cycle abort pulse, coincident with `done`.

## Operation
- States: IDLE, WAIT_MEM, COMMIT. Reset state IDLE.
- IDLE:
  - On accept, capture `wb_sel`, `funct3`, `rd_in`, `alu_result`, `pc_plus4` and `imm`.
  - LOAD goes to WAIT_MEM. All other sources go to COMMIT.
- WAIT_MEM:
  - On `mem_rvalid`, extract the result and go to COMMIT.
  - Extraction by funct3, with `off` = captured `alu_result[1:0]`:
    - 000 LB: sign-extend byte `off`.
    - 100 LBU: zero-extend byte `off`.
    - 001 LH: sign-extend halfword `off[1]`.
    - 101 LHU: zero-extend halfword `off[1]`.
    - 010, 011, 110, 111: full word.
  - Byte n means `mem_rdata[8n+7:8n]` (little-endian).
- COMMIT:
  - `done`=1 for one cycle.
  - `reg_write_enable`=1 unless rd = 0 or `fault`.
  - Returns to IDLE.
- `rd_data`: the selected source (ALU, extracted load, PC+4 or IMM). `rd_data` and `rd_addr` are valid only while `reg_write_enable` or `done` is high.
- `busy` = 1 in WAIT_MEM and COMMIT.
  - `wb_valid` while busy is ignored; upstream must hold it.
  - `mem_rvalid` outside WAIT_MEM is ignored.
- Timeout:
  - An 8-bit counter clears on entering WAIT_MEM and increments on each WAIT_MEM cycle without `mem_rvalid`.
  - If TIMEOUT WAIT_MEM cycles pass with no `mem_rvalid`, the unit goes to COMMIT with `fault`=1 and no write.
  - `mem_rvalid` on the final allowed cycle wins over the timeout.
- rd = 0: `done` still pulses; the write is suppressed.

## Timing
- All outputs are registered. Reset value of every output is 0, including `busy`.
- Non-load accepted at cycle T: `reg_write_enable`/`done` high during T+1; register written at the end of T+1; `busy` high during T+1.
- Load accepted at T, `mem_rvalid` first seen at cycle T+k (k ≥ 1): COMMIT at T+k+1.
- Load with no `mem_rvalid`: COMMIT with `fault` at T+TIMEOUT+1.
- Peak throughput: one instruction per 2 cycles. The next accept is possible in the cycle after COMMIT.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and zeroes all outputs and captured state.
  - No write occurs.
  - The in-flight instruction is dropped.

## Configuration
- Macro `WB_MISALIGN_CHECK_EN`.
- Defined: a misaligned load faults in COMMIT with `fault`=1 and no write, at the same latency as a normal load.
  - LH/LHU with `off[0]`=1 is misaligned.
  - LW with `off` ≠ 0 is misaligned.
- Undefined:
  - No misalignment check.
  - Halfword loads use `off[1]` only.
  - Word loads ignore `off`.
  - `fault` is driven only by timeout.

## Test plan
- ALU writeback: `wb_sel`=00, rd=5, `alu_result`=0x0000_1234, accept at T -> T+1: `reg_write_enable`=1, `rd_addr`=5, `rd_data`=0x0000_1234, `done`=1; T+2: all low.
- Load extraction: `mem_rdata`=0x80FF_7F01, `mem_rvalid` 3 cycles after accept:
  - LB `off`=3 -> 0xFFFF_FF80.
  - LBU `off`=3 -> 0x0000_0080.
  - LH `off`=2 -> 0xFFFF_80FF.
  - LHU `off`=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
  - Each COMMIT occurs 4 cycles after accept.
- rd=0: `wb_sel`=10, `pc_plus4`=0x104 -> `done`=1, `reg_write_enable`=0.
- Timeout: TIMEOUT=4, load with no `mem_rvalid` -> `fault`=`done`=1 at T+5, no write.
  - Repeat with `mem_rvalid` at T+4 -> normal write at T+5, `fault`=0.
- Misalignment (macro defined): LW with `alu_result`=0x1002 -> `fault`=1, no write.
  - Macro undefined: same stimulus writes the full `mem_rdata` word.
- Busy and reset: `wb_valid` held during WAIT_MEM -> not accepted until after COMMIT.
  - `rst_n` pulsed low in WAIT_MEM -> outputs 0 immediately.
  - Later `mem_rvalid` -> no write.

Source files
------------

// File: rtl/writeback_unit.sv
// RV32I writeback stage: selects the result source, waits for load data, extracts/extends it.
// Latency: non-load commits 1 cycle after accept; load commits 1 cycle after mem_rvalid or TIMEOUT.
// Backpressure: busy outside IDLE, wb_valid ignored while busy. Misaligned-load faults: WB_MISALIGN_CHECK_EN.
module writeback_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [1:0]  wb_sel,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] imm,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        reg_write_enable,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] imm_q, imm_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  logic        misaligned;

  function automatic logic [31:0] src_mux(input logic [1:0]  sel,
                                          input logic [31:0] alu_v,
                                          input logic [31:0] pc4_v,
                                          input logic [31:0] imm_v,
                                          input logic [31:0] load_v);
    logic [31:0] r;
    case (sel)
      SEL_ALU:  r = alu_v;
      SEL_LOAD: r = load_v;
      SEL_PC4:  r = pc4_v;
      default:  r = imm_v;
    endcase
    return r;
  endfunction

  // Little-endian: byte n is word[8n+7:8n]; halfwords select on off[1] only.
  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef WB_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (funct3_q)
      3'b001, 3'b101: misaligned = addr_q[0];
      3'b010, 3'b011, 3'b110, 3'b111: misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    pc4_d     = pc4_q;
    imm_d     = imm_q;
    cnt_d     = cnt_q;
    // Outputs are nonzero only for the single COMMIT cycle.
    rd_addr_d = 5'd0;
    rd_data_d = 32'd0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    fault_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wb_valid && !busy_q) begin
          sel_d    = wb_sel;
          funct3_d = funct3;
          rd_d     = rd_in;
          addr_d   = alu_result;
          pc4_d    = pc_plus4;
          imm_d    = imm;
          cnt_d    = 8'd0;
          if (wb_sel == SEL_LOAD) begin
            state_d = S_WAIT_MEM;
          end else begin
            state_d   = S_COMMIT;
            done_d    = 1'b1;
            rd_addr_d = rd_in;
            rd_data_d = src_mux(wb_sel, alu_result, pc_plus4, imm, 32'd0);
            we_d      = (rd_in != 5'd0);
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d   = S_COMMIT;
          done_d    = 1'b1;
          rd_addr_d = rd_q;
          fault_d   = misaligned;
          if (!misaligned) begin
            rd_data_d = src_mux(sel_q, addr_q, pc4_q, imm_q,
                                extract(funct3_q, addr_q[1:0], mem_rdata));
          end
          we_d      = (rd_q != 5'd0) && !misaligned;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_COMMIT;
          done_d    = 1'b1;
          fault_d   = 1'b1;
          rd_addr_d = rd_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      funct3_q  <= 3'd0;
      rd_q      <= 5'd0;
      addr_q    <= 32'd0;
      pc4_q     <= 32'd0;
      imm_q     <= 32'd0;
      cnt_q     <= 8'd0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      pc4_q     <= pc4_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign rd_addr          = rd_addr_q;
  assign rd_data          = rd_data_q;
  assign reg_write_enable = we_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit (TIMEOUT=4); commit records are checked as they retire.
module tb_writeback_unit;

  localparam int TO = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        we;
    logic        f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [4:0]  rd_in = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [31:0] imm = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write_enable;
  logic        busy;
  logic        done;
  logic        fault;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  writeback_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_sel(wb_sel), .funct3(funct3),
    .rd_in(rd_in), .alu_result(alu_result), .pc_plus4(pc_plus4), .imm(imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write_enable(reg_write_enable), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (reg_write_enable && !done) begin
        n_bad++;
        $display("FAIL we_without_done: reg_write_enable=1 done=0");
      end
      if (done) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected_done: rd_addr=%0d rd_data=%h we=%b fault=%b, no commit expected",
                   rd_addr, rd_data, reg_write_enable, fault);
        end else begin
          e = sb.pop_front();
          if (reg_write_enable !== e.we || fault !== e.f ||
              (e.we && (rd_addr !== e.a || rd_data !== e.d))) begin
            n_bad++;
            $display("FAIL sb_commit: got rd_addr=%0d rd_data=%h we=%b fault=%b, want rd_addr=%0d rd_data=%h we=%b fault=%b",
                     rd_addr, rd_data, reg_write_enable, fault, e.a, e.d, e.we, e.f);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic we, input logic f);
    exp_t e;
    e.a = a; e.d = d; e.we = we; e.f = f;
    sb.push_back(e);
  endtask

  task automatic offer(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] im);
    wb_valid = 1'b1; wb_sel = sel; funct3 = f3; rd_in = rd;
    alu_result = alu; pc_plus4 = pc4; imm = im;
  endtask

  // Issues a load and returns commit latency in cycles after accept (0 = no done seen).
  task automatic run_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] rdata, input int k, output int lat);
    offer(2'b01, f3, rd, addr, 32'd0, 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    mem_rdata = rdata;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      mem_rvalid = (c == k);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    n_vec++;
    if ({rd_addr, rd_data, reg_write_enable, busy, done, fault} !== 41'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%0d data=%h we=%b busy=%b done=%b fault=%b, want all 0",
               rd_addr, rd_data, reg_write_enable, busy, done, fault);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nonload;
    logic [1:0]  sels[3] = '{2'b00, 2'b11, 2'b10};
    logic [4:0]  rds[3]  = '{5'd5, 5'd31, 5'd1};
    logic [31:0] vals[3] = '{32'h0000_1234, 32'hDEAD_B000, 32'h0000_0208};
    for (int i = 0; i < 3; i++) begin
      offer(sels[i], 3'b000, rds[i],
            (sels[i] == 2'b00) ? vals[i] : 32'h5555_5555,
            (sels[i] == 2'b10) ? vals[i] : 32'h6666_6666,
            (sels[i] == 2'b11) ? vals[i] : 32'h7777_7777);
      push_exp(rds[i], vals[i], 1'b1, 1'b0);
      @(posedge clk); #1;
      wb_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({done, reg_write_enable, busy, fault} !== 4'b1110) begin
        n_bad++;
        $display("FAIL nonload_t1[%0d]: got done/we/busy/fault=%b, want 1110", i,
                 {done, reg_write_enable, busy, fault});
      end
      @(negedge clk);
      n_vec++;
      if ({done, reg_write_enable, busy, fault} !== 4'b0000) begin
        n_bad++;
        $display("FAIL nonload_t2[%0d]: got done/we/busy/fault=%b, want 0000", i,
                 {done, reg_write_enable, busy, fault});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rd0;
    offer(2'b10, 3'b000, 5'd0, 32'd0, 32'h0000_0104, 32'd0);
    push_exp(5'd0, 32'h0000_0104, 1'b0, 1'b0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || reg_write_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL rd0: got done=%b we=%b, want done=1 we=0", done, reg_write_enable);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loads;
    logic [2:0]  f3s[8]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000, 3'b001};
    logic [31:0] addrs[8] = '{32'h2003, 32'h2003, 32'h2002, 32'h2000, 32'h2000, 32'h2001, 32'h2000, 32'h2000};
    logic [31:0] exps[8]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                              32'h80FF_7F01, 32'h0000_007F, 32'h0000_0001, 32'h0000_7F01};
    int lat;
    for (int i = 0; i < 8; i++) begin
      push_exp(5'(i + 2), exps[i], 1'b1, 1'b0);
      run_load(f3s[i], 5'(i + 2), addrs[i], 32'h80FF_7F01, 3, lat);
      n_vec++;
      if (lat !== 4) begin
        n_bad++;
        $display("FAIL load_latency[%0d]: got %0d cycles, want 4", i, lat);
      end
    end
  endtask

  task automatic test_timeout;
    int lat;
    push_exp(5'd9, 32'd0, 1'b0, 1'b1);
    run_load(3'b010, 5'd9, 32'h3000, 32'h1111_2222, 0, lat);
    n_vec++;
    if (lat !== TO + 1) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, want %0d", lat, TO + 1);
    end
    push_exp(5'd9, 32'h1111_2222, 1'b1, 1'b0);
    run_load(3'b010, 5'd9, 32'h3000, 32'h1111_2222, TO, lat);
    n_vec++;
    if (lat !== TO + 1) begin
      n_bad++;
      $display("FAIL rvalid_last_cycle_latency: got %0d cycles, want %0d", lat, TO + 1);
    end
    push_exp(5'd8, 32'h0000_0022, 1'b1, 1'b0);
    run_load(3'b100, 5'd8, 32'h3000, 32'h1111_2222, 1, lat);
    n_vec++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL rvalid_first_cycle_latency: got %0d cycles, want 2", lat);
    end
  endtask

  task automatic test_misalign;
    int lat;
`ifdef WB_MISALIGN_CHECK_EN
    push_exp(5'd10, 32'd0, 1'b0, 1'b1);
    push_exp(5'd11, 32'd0, 1'b0, 1'b1);
`else
    push_exp(5'd10, 32'h80FF_7F01, 1'b1, 1'b0);
    push_exp(5'd11, 32'h0000_7F01, 1'b1, 1'b0);
`endif
    run_load(3'b010, 5'd10, 32'h1002, 32'h80FF_7F01, 3, lat);
    n_vec++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL misalign_lw_latency: got %0d cycles, want 4", lat);
    end
    run_load(3'b001, 5'd11, 32'h1001, 32'h80FF_7F01, 3, lat);
    n_vec++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL misalign_lh_latency: got %0d cycles, want 4", lat);
    end
  endtask

  task automatic test_busy_reset;
    logic [1:0] want_db[4] = '{2'b01, 2'b01, 2'b11, 2'b00};
    // Load accepted, then an ALU op held on wb_valid throughout the load.
    offer(2'b01, 3'b010, 5'd11, 32'h4000, 32'd0, 32'd0);
    push_exp(5'd11, 32'hCAFE_F00D, 1'b1, 1'b0);
    @(posedge clk); #1;
    offer(2'b00, 3'b000, 5'd7, 32'h0000_ABCD, 32'd0, 32'd0);
    push_exp(5'd7, 32'h0000_ABCD, 1'b1, 1'b0);
    mem_rdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 4; c++) begin
      mem_rvalid = (c == 2);
      @(negedge clk);
      n_vec++;
      if ({done, busy} !== want_db[c-1]) begin
        n_bad++;
        $display("FAIL busy_hold[%0d]: got done/busy=%b, want %b", c, {done, busy}, want_db[c-1]);
      end
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || rd_addr !== 5'd7) begin
      n_bad++;
      $display("FAIL held_accept: got done=%b rd_addr=%0d, want done=1 rd_addr=7", done, rd_addr);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_rvalid: got done=%b busy=%b, want 0 0", done, busy);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    // Reset in the middle of WAIT_MEM drops the load.
    offer(2'b01, 3'b010, 5'd12, 32'h5000, 32'd0, 32'd0);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({rd_addr, rd_data, reg_write_enable, busy, done, fault} !== 41'd0) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got addr=%0d data=%h we=%b busy=%b done=%b fault=%b, want all 0",
               rd_addr, rd_data, reg_write_enable, busy, done, fault);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || reg_write_enable !== 1'b0) begin
        n_bad++;
        $display("FAIL post_reset_rvalid[%0d]: got done=%b we=%b, want 0 0", c, done, reg_write_enable);
      end
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_rd0();
    test_loads();
    test_timeout();
    test_misalign();
    test_busy_reset();
    repeat (2) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending commits, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
